// File: rtl/regfile_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hazard_if
// Purpose  : decode/writeback bus between a pipeline front end and the
//            register file + hazard unit.
// Revision : 1.0
// ============================================================================
interface regfile_hazard_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
);
  logic [AW-1:0]     a1;
  logic [AW-1:0]     a2;
  logic              use1;
  logic              use2;
  logic              issue_valid;
  logic              issue_wr;
  logic [AW-1:0]     issue_dst;
  logic              flush;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output a1, a2, use1, use2, issue_valid, issue_wr, issue_dst, flush,
           wb_en, wb_addr, wb_data,
    input  rd1, rd2, fwd_a, fwd_b, stall, stall_cnt
  );

  modport slave (
    input  a1, a2, use1, use2, issue_valid, issue_wr, issue_dst, flush,
           wb_en, wb_addr, wb_data,
    output rd1, rd2, fwd_a, fwd_b, stall, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hazard_unit
// Purpose  : register file with write-through reads, E/M/W destination tag
//            pipeline, forwarding selects, stall generation and stall counter.
// Revision : 1.0
// ============================================================================
module regfile_hazard_unit #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int FWD_EN   = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input wire              clk,
  input wire              rst,
  regfile_hazard_if.slave bus
);

  localparam int               c_aw      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam bit               c_fwd_en  = (FWD_EN != 0);
  localparam bit               c_zero_en = (ZERO_REG != 0);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [1:0]       c_fwd_reg = 2'b00;
  localparam logic [1:0]       c_fwd_m   = 2'b01;
  localparam logic [1:0]       c_fwd_w   = 2'b10;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_e_valid;
  logic              r_m_valid;
  logic              r_w_valid;
  logic [c_aw-1:0]   r_e_dst;
  logic [c_aw-1:0]   r_m_dst;
  logic [c_aw-1:0]   r_w_dst;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_wb_ok;
  logic              w_a1_zero;
  logic              w_a2_zero;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_src1_e;
  logic              w_src2_e;
  logic              w_src1_m;
  logic              w_src2_m;
  logic              w_src1_w;
  logic              w_src2_w;
  logic              w_hazard;
  logic              w_stall;
  logic              w_issue;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // A write to register 0 is dropped entirely when it is hardwired to zero.
  assign w_wb_ok   = bus.wb_en & ~(c_zero_en & (bus.wb_addr == '0));
  assign w_a1_zero = c_zero_en & (bus.a1 == '0);
  assign w_a2_zero = c_zero_en & (bus.a2 == '0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_regs[gi] <= '0;
      end else if (w_wb_ok && (bus.wb_addr == c_aw'(gi))) begin
        r_regs[gi] <= bus.wb_data;
      end
    end
  end

  always_comb begin
    w_rd1 = r_regs[bus.a1];
    w_rd2 = r_regs[bus.a2];
    if (w_wb_ok && (bus.wb_addr == bus.a1)) w_rd1 = bus.wb_data;
    if (w_wb_ok && (bus.wb_addr == bus.a2)) w_rd2 = bus.wb_data;
    if (w_a1_zero) w_rd1 = '0;
    if (w_a2_zero) w_rd2 = '0;
  end

  assign w_src1_e = bus.use1 & r_e_valid & (r_e_dst == bus.a1) & ~w_a1_zero;
  assign w_src2_e = bus.use2 & r_e_valid & (r_e_dst == bus.a2) & ~w_a2_zero;
  assign w_src1_m = bus.use1 & r_m_valid & (r_m_dst == bus.a1) & ~w_a1_zero;
  assign w_src2_m = bus.use2 & r_m_valid & (r_m_dst == bus.a2) & ~w_a2_zero;
  assign w_src1_w = bus.use1 & r_w_valid & (r_w_dst == bus.a1) & ~w_a1_zero;
  assign w_src2_w = bus.use2 & r_w_valid & (r_w_dst == bus.a2) & ~w_a2_zero;

  // Without forwarding, an M-stage producer must also be waited out.
  always_comb begin
    w_hazard = w_src1_e | w_src2_e;
    if (!c_fwd_en) w_hazard = w_hazard | w_src1_m | w_src2_m;
    w_stall = w_hazard & bus.issue_valid & ~bus.flush;
    w_fwd_a = c_fwd_reg;
    w_fwd_b = c_fwd_reg;
    if (c_fwd_en && !w_stall) begin
      if (w_src1_m)      w_fwd_a = c_fwd_m;
      else if (w_src1_w) w_fwd_a = c_fwd_w;
      if (w_src2_m)      w_fwd_b = c_fwd_m;
      else if (w_src2_w) w_fwd_b = c_fwd_w;
    end
  end

  assign w_issue = bus.issue_valid & bus.issue_wr & ~w_stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_w_valid <= 1'b0;
      r_e_dst   <= '0;
      r_m_dst   <= '0;
      r_w_dst   <= '0;
    end else begin
      r_w_valid <= r_m_valid;
      r_w_dst   <= r_m_dst;
      r_m_valid <= r_e_valid;
      r_m_dst   <= r_e_dst;
      r_e_valid <= w_issue;
      r_e_dst   <= bus.issue_dst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.rd1       = w_rd1;
  assign bus.rd2       = w_rd2;
  assign bus.fwd_a     = w_fwd_a;
  assign bus.fwd_b     = w_fwd_b;
  assign bus.stall     = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_hazard_unit
// Purpose  : directed bench for regfile_hazard_unit in three configurations.
// Revision : 1.0
// ============================================================================
module tb_regfile_hazard_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  a1, a2, issue_dst, wb_addr;
  logic        use1, use2, issue_valid, issue_wr, flush, wb_en;
  logic [15:0] wb_data;
  int          total;
  int          bad;

  // if0/u0: forwarding; if1/u1: stall-only; if2/u2: stall-only, zero reg, 3-bit counter
  regfile_hazard_if #(.DATA_W(16), .AW(3), .CNT_W(16)) if0 ();
  regfile_hazard_if #(.DATA_W(16), .AW(3), .CNT_W(16)) if1 ();
  regfile_hazard_if #(.DATA_W(16), .AW(3), .CNT_W(3))  if2 ();

  assign if0.a1 = a1;  assign if0.a2 = a2;  assign if0.use1 = use1;  assign if0.use2 = use2;
  assign if0.issue_valid = issue_valid;  assign if0.issue_wr = issue_wr;  assign if0.issue_dst = issue_dst;
  assign if0.flush = flush;  assign if0.wb_en = wb_en;  assign if0.wb_addr = wb_addr;  assign if0.wb_data = wb_data;
  assign if1.a1 = a1;  assign if1.a2 = a2;  assign if1.use1 = use1;  assign if1.use2 = use2;
  assign if1.issue_valid = issue_valid;  assign if1.issue_wr = issue_wr;  assign if1.issue_dst = issue_dst;
  assign if1.flush = flush;  assign if1.wb_en = wb_en;  assign if1.wb_addr = wb_addr;  assign if1.wb_data = wb_data;
  assign if2.a1 = a1;  assign if2.a2 = a2;  assign if2.use1 = use1;  assign if2.use2 = use2;
  assign if2.issue_valid = issue_valid;  assign if2.issue_wr = issue_wr;  assign if2.issue_dst = issue_dst;
  assign if2.flush = flush;  assign if2.wb_en = wb_en;  assign if2.wb_addr = wb_addr;  assign if2.wb_data = wb_data;

  regfile_hazard_unit #(.DATA_W(16), .NREGS(8), .FWD_EN(1), .ZERO_REG(0), .CNT_W(16))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_hazard_unit #(.DATA_W(16), .NREGS(8), .FWD_EN(0), .ZERO_REG(0), .CNT_W(16))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  regfile_hazard_unit #(.DATA_W(16), .NREGS(8), .FWD_EN(0), .ZERO_REG(1), .CNT_W(3))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    a1 = '0; a2 = '0; use1 = 0; use2 = 0; issue_valid = 0; issue_wr = 0;
    issue_dst = '0; flush = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    total++; if (if0.rd1 !== 16'h0)   begin bad++; $display("FAIL reset_rd1 got=%h exp=0000", if0.rd1); end
    total++; if (if0.rd2 !== 16'h0)   begin bad++; $display("FAIL reset_rd2 got=%h exp=0000", if0.rd2); end
    total++; if (if0.fwd_a !== 2'b00) begin bad++; $display("FAIL reset_fwd_a got=%b exp=00", if0.fwd_a); end
    total++; if (if0.fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd_b got=%b exp=00", if0.fwd_b); end
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL reset_stall got=%b exp=0", if0.stall); end
    total++; if (if0.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", if0.stall_cnt); end
    total++; if (if2.stall_cnt !== 3'd0)  begin bad++; $display("FAIL reset_cnt_u2 got=%0d exp=0", if2.stall_cnt); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_write_through();
    do_reset();
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF; a1 = 3'd3; a2 = 3'd5;
    #2;
    total++; if (if0.rd1 !== 16'hBEEF) begin bad++; $display("FAIL wt_rd1_bypass got=%h exp=beef", if0.rd1); end
    total++; if (if0.rd2 !== 16'h0000) begin bad++; $display("FAIL wt_rd2_empty got=%h exp=0000", if0.rd2); end
    tick();
    wb_en = 0;
    #2;
    total++; if (if0.rd1 !== 16'hBEEF) begin bad++; $display("FAIL wt_rd1_stored got=%h exp=beef", if0.rd1); end
    wb_en = 1; wb_addr = 3'd5; wb_data = 16'h55AA;
    #1;
    total++; if (if0.rd2 !== 16'h55AA) begin bad++; $display("FAIL wt_rd2_bypass got=%h exp=55aa", if0.rd2); end
    tick();
    wb_en = 0;
    #2;
    total++; if (if0.rd2 !== 16'h55AA) begin bad++; $display("FAIL wt_rd2_stored got=%h exp=55aa", if0.rd2); end
    total++; if (if0.rd1 !== 16'hBEEF) begin bad++; $display("FAIL wt_rd1_kept got=%h exp=beef", if0.rd1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_dst = 3'd2;
    #2;
    total++; if (if0.stall !== 1'b0) begin bad++; $display("FAIL b2b_issue_stall got=%b exp=0", if0.stall); end
    tick();
    issue_wr = 0; use1 = 1; a1 = 3'd2;
    #2;
    total++; if (if0.stall !== 1'b1)  begin bad++; $display("FAIL b2b_fwd_stall1 got=%b exp=1", if0.stall); end
    total++; if (if0.fwd_a !== 2'b00) begin bad++; $display("FAIL b2b_fwd_a1 got=%b exp=00", if0.fwd_a); end
    total++; if (if1.stall !== 1'b1)  begin bad++; $display("FAIL b2b_so_stall1 got=%b exp=1", if1.stall); end
    tick();
    #1;
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL b2b_fwd_stall2 got=%b exp=0", if0.stall); end
    total++; if (if0.fwd_a !== 2'b01) begin bad++; $display("FAIL b2b_fwd_a2 got=%b exp=01", if0.fwd_a); end
    total++; if (if1.stall !== 1'b1)  begin bad++; $display("FAIL b2b_so_stall2 got=%b exp=1", if1.stall); end
    total++; if (if1.fwd_a !== 2'b00) begin bad++; $display("FAIL b2b_so_fwd_a2 got=%b exp=00", if1.fwd_a); end
    tick();
    #1;
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL b2b_fwd_stall3 got=%b exp=0", if0.stall); end
    total++; if (if0.fwd_a !== 2'b10) begin bad++; $display("FAIL b2b_fwd_a3 got=%b exp=10", if0.fwd_a); end
    total++; if (if1.stall !== 1'b0)  begin bad++; $display("FAIL b2b_so_stall3 got=%b exp=0", if1.stall); end
    total++; if (if1.fwd_a !== 2'b00) begin bad++; $display("FAIL b2b_so_fwd_a3 got=%b exp=00", if1.fwd_a); end
    total++; if (if0.stall_cnt !== 16'd1) begin bad++; $display("FAIL b2b_fwd_cnt got=%0d exp=1", if0.stall_cnt); end
    total++; if (if1.stall_cnt !== 16'd2) begin bad++; $display("FAIL b2b_so_cnt got=%0d exp=2", if1.stall_cnt); end
    idle();
  endtask

  task automatic test_fwd_priority();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_dst = 3'd4;
    tick();
    tick();
    issue_valid = 0; issue_wr = 0; use1 = 1; a1 = 3'd4;
    #2;
    total++; if (if0.stall !== 1'b0) begin bad++; $display("FAIL prio_novalid_stall got=%b exp=0", if0.stall); end
    total++; if (if1.stall !== 1'b0) begin bad++; $display("FAIL prio_novalid_so_stall got=%b exp=0", if1.stall); end
    tick();
    issue_valid = 1; use2 = 1; a2 = 3'd4;
    #2;
    total++; if (if0.fwd_a !== 2'b01) begin bad++; $display("FAIL prio_fwd_a got=%b exp=01", if0.fwd_a); end
    total++; if (if0.fwd_b !== 2'b01) begin bad++; $display("FAIL prio_fwd_b got=%b exp=01", if0.fwd_b); end
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL prio_stall got=%b exp=0", if0.stall); end
    total++; if (if1.stall !== 1'b1)  begin bad++; $display("FAIL prio_so_stall got=%b exp=1", if1.stall); end
    total++; if (if1.fwd_b !== 2'b00) begin bad++; $display("FAIL prio_so_fwd_b got=%b exp=00", if1.fwd_b); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_dst = 3'd6;
    tick();
    issue_dst = 3'd5; use1 = 1; a1 = 3'd6; flush = 1;
    #2;
    total++; if (if0.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", if0.stall); end
    total++; if (if1.stall !== 1'b0) begin bad++; $display("FAIL flush_so_stall got=%b exp=0", if1.stall); end
    tick();
    flush = 0; issue_wr = 0; use2 = 1; a2 = 3'd5;
    #2;
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL flush_after_stall got=%b exp=0", if0.stall); end
    total++; if (if0.fwd_a !== 2'b01) begin bad++; $display("FAIL flush_after_fwd_a got=%b exp=01", if0.fwd_a); end
    total++; if (if0.fwd_b !== 2'b00) begin bad++; $display("FAIL flush_bubble_fwd_b got=%b exp=00", if0.fwd_b); end
    total++; if (if1.stall !== 1'b1)  begin bad++; $display("FAIL flush_after_so_stall got=%b exp=1", if1.stall); end
    idle();
  endtask

  task automatic test_zero_unused();
    do_reset();
    wb_en = 1; wb_addr = 3'd0; wb_data = 16'h1234; use1 = 1; a1 = 3'd0;
    issue_valid = 1; issue_wr = 1; issue_dst = 3'd0;
    #2;
    total++; if (if2.rd1 !== 16'h0000) begin bad++; $display("FAIL zero_rd1_bypass got=%h exp=0000", if2.rd1); end
    total++; if (if0.rd1 !== 16'h1234) begin bad++; $display("FAIL nonzero_rd1_bypass got=%h exp=1234", if0.rd1); end
    tick();
    wb_en = 0; issue_wr = 0;
    #2;
    total++; if (if2.rd1 !== 16'h0000) begin bad++; $display("FAIL zero_rd1_stored got=%h exp=0000", if2.rd1); end
    total++; if (if0.rd1 !== 16'h1234) begin bad++; $display("FAIL nonzero_rd1_stored got=%h exp=1234", if0.rd1); end
    total++; if (if2.stall !== 1'b0)   begin bad++; $display("FAIL zero_no_hazard got=%b exp=0", if2.stall); end
    total++; if (if1.stall !== 1'b1)   begin bad++; $display("FAIL nonzero_so_hazard got=%b exp=1", if1.stall); end
    total++; if (if0.stall !== 1'b1)   begin bad++; $display("FAIL nonzero_hazard got=%b exp=1", if0.stall); end
    use1 = 0;
    #1;
    total++; if (if0.stall !== 1'b0)   begin bad++; $display("FAIL unused_src_stall got=%b exp=0", if0.stall); end
    total++; if (if1.stall !== 1'b0)   begin bad++; $display("FAIL unused_src_so_stall got=%b exp=0", if1.stall); end
    idle();
  endtask

  task automatic test_saturation_reset();
    do_reset();
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    issue_valid = 1; issue_wr = 1; issue_dst = 3'd7; use1 = 1; a1 = 3'd7; use2 = 1; a2 = 3'd3;
    tick();
    wb_en = 0;
    for (int i = 0; i < 15; i++) tick();
    #1;
    total++; if (if2.stall !== 1'b1)     begin bad++; $display("FAIL sat_stall got=%b exp=1", if2.stall); end
    total++; if (if2.stall_cnt !== 3'd7) begin bad++; $display("FAIL sat_cnt got=%0d exp=7", if2.stall_cnt); end
    total++; if (if2.rd2 !== 16'hBEEF)   begin bad++; $display("FAIL sat_rd2 got=%h exp=beef", if2.rd2); end
    tick();
    #1;
    total++; if (if2.stall !== 1'b1)     begin bad++; $display("FAIL sat_stall2 got=%b exp=1", if2.stall); end
    total++; if (if2.stall_cnt !== 3'd7) begin bad++; $display("FAIL sat_nowrap got=%0d exp=7", if2.stall_cnt); end
    rst = 1'b0;
    #1;
    total++; if (if2.stall_cnt !== 3'd0)  begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", if2.stall_cnt); end
    total++; if (if2.stall !== 1'b0)      begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", if2.stall); end
    total++; if (if2.rd2 !== 16'h0000)    begin bad++; $display("FAIL rst_mid_rd2 got=%h exp=0000", if2.rd2); end
    total++; if (if0.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt_u0 got=%0d exp=0", if0.stall_cnt); end
    total++; if (if0.stall !== 1'b0)      begin bad++; $display("FAIL rst_mid_stall_u0 got=%b exp=0", if0.stall); end
    total++; if (if1.stall !== 1'b0)      begin bad++; $display("FAIL rst_mid_stall_u1 got=%b exp=0", if1.stall); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (if2.stall !== 1'b0)  begin bad++; $display("FAIL rst_rel_stall got=%b exp=0", if2.stall); end
    total++; if (if0.fwd_a !== 2'b00) begin bad++; $display("FAIL rst_rel_fwd_a got=%b exp=00", if0.fwd_a); end
    total++; if (if0.stall !== 1'b0)  begin bad++; $display("FAIL rst_rel_stall_u0 got=%b exp=0", if0.stall); end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_through();
    test_back_to_back();
    test_fwd_priority();
    test_flush();
    test_zero_unused();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
